// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, size decode.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_STORE_RD = 3'd2,
    ST_STORE_WR = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus doubleword memory bus of the load/store unit.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
interface lsu_if #(parameter int ADDR_WIDTH = 64);
  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [2:0]            ReqFunct3;
  logic [ADDR_WIDTH-1:0] ReqAddress;
  logic [63:0]           ReqWriteData;
  logic                  RespValid;
  logic                  RespReady;
  logic [63:0]           RespReadData;
  logic                  RespError;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic                  MemRead;
  logic                  MemWrite;
  logic [63:0]           MemWriteData;
  logic [63:0]           MemReadData;

  modport slave (
    input  ReqValid, ReqWrite, ReqFunct3, ReqAddress, ReqWriteData, RespReady, MemReadData,
    output ReqReady, RespValid, RespReadData, RespError, MemAddress, MemRead, MemWrite,
           MemWriteData
  );

  modport master (
    output ReqValid, ReqWrite, ReqFunct3, ReqAddress, ReqWriteData, RespReady, MemReadData,
    input  ReqReady, RespValid, RespReadData, RespError, MemAddress, MemRead, MemWrite,
           MemWriteData
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend and store merge within a doubleword.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] mem_data,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] load_value,
  input  logic [63:0] old_data,
  input  logic [63:0] store_data,
  input  logic [3:0]  size,
  output logic [63:0] merged
);

  logic [63:0] shifted;
  logic [63:0] store_shifted;
  logic [3:0]  lo;
  logic [3:0]  hi;

  always_comb begin
    shifted = mem_data >> {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   load_value = funct3[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   load_value = funct3[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_value = funct3[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_value = shifted;
    endcase
  end

  // Store data is moved up to its byte lane, then only lanes [offset, offset+size) are taken.
  always_comb begin
    store_shifted = store_data << {offset, 3'b000};
    lo            = {1'b0, offset};
    hi            = lo + size;
    merged        = old_data;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) >= lo) && (4'(i) < hi)) merged[8*i +: 8] = store_shifted[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64I load/store unit: legality check, doubleword memory access, read-modify-write stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter logic [63:0] RESET_DATA = 64'h0
) (
  input  logic       Clock,
  input  logic       Reset,
  lsu_if.slave       bus,
  output lsu_state_t dbg_state
);

  lsu_state_t            state;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_error;
  logic [63:0]           resp_data;
  logic                  mem_read;
  logic                  mem_write;
  logic                  cap_write;
  logic [2:0]            cap_funct3;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [63:0]           cap_wdata;
  logic [63:0]           merge_q;

  logic [3:0]  req_size;
  logic [3:0]  req_size_m1;
  logic        illegal;
  logic        misaligned;
  logic [63:0] load_value;
  logic [63:0] merged;

  always_comb begin
    req_size    = size_bytes(bus.ReqFunct3);
    req_size_m1 = req_size - 4'd1;
    illegal     = bus.ReqWrite ? bus.ReqFunct3[2] : (bus.ReqFunct3 == 3'b111);
    misaligned  = |(bus.ReqAddress[2:0] & req_size_m1[2:0]);
  end

  lsu_align u_align (
    .mem_data   (bus.MemReadData),
    .offset     (cap_addr[2:0]),
    .funct3     (cap_funct3),
    .load_value (load_value),
    .old_data   (merge_q),
    .store_data (cap_wdata),
    .size       (size_bytes(cap_funct3)),
    .merged     (merged)
  );

  // Memory enables are registered alongside the state so they are glitch-free and reset-cleared.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_data  <= RESET_DATA;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      cap_write  <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      merge_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ReqValid && req_ready) begin
            cap_write  <= bus.ReqWrite;
            cap_funct3 <= bus.ReqFunct3;
            cap_addr   <= bus.ReqAddress;
            cap_wdata  <= bus.ReqWriteData;
            req_ready  <= 1'b0;
            resp_data  <= '0;
            resp_error <= illegal || misaligned;
            if (illegal || misaligned) begin
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (!bus.ReqWrite) begin
              mem_read <= 1'b1;
              state    <= ST_LOAD;
            end else if (bus.ReqFunct3[1:0] == 2'b11) begin
              mem_write <= 1'b1;
              state     <= ST_STORE_WR;
            end else begin
              mem_read <= 1'b1;
              state    <= ST_STORE_RD;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          resp_data  <= load_value;
          mem_read   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_STORE_RD: begin
          merge_q   <= bus.MemReadData;
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          state     <= ST_STORE_WR;
        end
        ST_STORE_WR: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.RespReady) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ReqReady     = req_ready;
  assign bus.RespValid    = resp_valid;
  assign bus.RespError    = resp_error;
  assign bus.RespReadData = resp_data;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.MemAddress   = {cap_addr[ADDR_WIDTH-1:3], 3'b000};
  assign bus.MemWriteData = merged;
  assign dbg_state        = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed sequence plus random requests against a byte-array model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic       Clock;
  logic       Reset;
  lsu_state_t dbg_state;
  lsu_if #(.ADDR_WIDTH(64)) bus();

  load_store_unit #(.ADDR_WIDTH(64), .RESET_DATA(64'h0)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // data memory seen by the DUT (16 doublewords), preloadable from the stimulus
  logic [63:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [63:0] pl_val;

  assign bus.MemReadData = mem[bus.MemAddress[6:3]];
  always @(posedge Clock) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (bus.MemWrite) mem[bus.MemAddress[6:3]] <= bus.MemWriteData;
  end

  // reference model: flat little-endian byte array
  logic [7:0]  ref_mem [128];
  int          checks;
  int          errors;
  logic [63:0] last_data;
  logic [63:0] last_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int idx);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[idx*8 + i];
    return v;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input int addr);
    int          sz;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    v  = '0;
    for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[addr + i]) << (8 * i));
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return v;
  endfunction

  // driver: one full request/response transaction, response held for 'hold' extra cycles
  task automatic do_req(input logic wr, input logic [2:0] f3, input int addr,
                        input logic [63:0] wd, input int hold);
    int          sz, n, lat, rd_n, wr_n, both_n, exp_lat, exp_rd, exp_wr;
    logic        err;
    logic [63:0] exp_data;
    sz  = 1 << f3[1:0];
    err = (wr ? f3[2] : (f3 == 3'b111)) || ((addr % sz) != 0);
    exp_data = '0;
    if (!err && !wr) exp_data = model_load(f3, addr);
    if (!err && wr) for (int i = 0; i < sz; i++) ref_mem[addr + i] = wd[8*i +: 8];
    exp_lat = err ? 1 : (!wr ? 2 : (sz == 8 ? 2 : 3));
    exp_rd  = (err || (wr && sz == 8)) ? 0 : 1;
    exp_wr  = (!err && wr) ? 1 : 0;

    @(negedge Clock);
    bus.ReqValid     = 1'b1;
    bus.ReqWrite     = wr;
    bus.ReqFunct3    = f3;
    bus.ReqAddress   = 64'(addr);
    bus.ReqWriteData = wd;
    n = 0;
    while (!bus.ReqReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("accept_timeout", 64'(n < 20), 64'd1);
    @(posedge Clock);
    #1;
    bus.ReqValid     = 1'b0;
    bus.ReqWrite     = 1'($urandom_range(0, 1));
    bus.ReqFunct3    = 3'($urandom_range(0, 7));
    bus.ReqAddress   = {$urandom, $urandom};
    bus.ReqWriteData = {$urandom, $urandom};

    lat = 0; rd_n = 0; wr_n = 0; both_n = 0;
    do begin
      @(negedge Clock);
      lat++;
      if (bus.MemRead) rd_n++;
      if (bus.MemWrite) begin
        wr_n++;
        last_wr = bus.MemWriteData;
      end
      if (bus.MemRead && bus.MemWrite) both_n++;
    end while (!bus.RespValid && lat < 10);

    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_error", 64'(bus.RespError), 64'(err));
    check("resp_data", bus.RespReadData, exp_data);
    check("mem_read_cycles", 64'(rd_n), 64'(exp_rd));
    check("mem_write_cycles", 64'(wr_n), 64'(exp_wr));
    check("read_write_overlap", 64'(both_n), 64'd0);
    if (exp_wr == 1) check("write_dword", last_wr, ref_dword(addr / 8));
    last_data = bus.RespReadData;

    for (int h = 0; h < hold; h++) begin
      bus.ReqValid   = 1'b1;
      bus.ReqWrite   = 1'b0;
      bus.ReqFunct3  = F3_LD;
      bus.ReqAddress = 64'd0;
      @(negedge Clock);
      check("hold_valid", 64'(bus.RespValid), 64'd1);
      check("hold_data", bus.RespReadData, exp_data);
      check("hold_ready", 64'(bus.ReqReady), 64'd0);
    end

    bus.RespReady = 1'b1;
    @(negedge Clock);
    bus.RespReady = 1'b0;
    bus.ReqValid  = 1'b0;
    check("resp_drop", 64'(bus.RespValid), 64'd0);
    check("idle_ready", 64'(bus.ReqReady), 64'd1);
    check("idle_state", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    int sz, addr;
    logic [2:0] f3;
    checks = 0; errors = 0;
    last_data = '0; last_wr = '0;
    Reset = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqFunct3 = '0;
    bus.ReqAddress = '0; bus.ReqWriteData = '0; bus.RespReady = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      pl_en  = 1'b1;
      pl_idx = 4'(i);
      pl_val = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = pl_val[8*b +: 8];
    end
    @(negedge Clock);
    pl_en = 1'b0;
    check("rst_resp_valid", 64'(bus.RespValid), 64'd0);
    check("rst_resp_error", 64'(bus.RespError), 64'd0);
    check("rst_resp_data", bus.RespReadData, 64'h0);
    check("rst_mem_read", 64'(bus.MemRead), 64'd0);
    check("rst_mem_write", 64'(bus.MemWrite), 64'd0);
    check("rst_req_ready", 64'(bus.ReqReady), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    Reset = 1'b0;

    do_req(1'b1, F3_SD, 8, 64'h1122334455667788, 0);
    do_req(1'b0, F3_LD, 8, 64'h0, 0);
    check("ld_after_sd", last_data, 64'h1122334455667788);
    do_req(1'b1, F3_SB, 11, 64'hAB, 0);
    check("sb_merge", last_wr, 64'h11223344AB667788);
    do_req(1'b0, F3_LBU, 11, 64'h0, 0);
    check("lbu", last_data, 64'hAB);
    do_req(1'b0, F3_LB, 11, 64'h0, 0);
    check("lb", last_data, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b1, F3_SH, 13, 64'h1234, 0);
    do_req(1'b0, F3_LW, 6, 64'h0, 0);
    do_req(1'b0, 3'b111, 16, 64'h0, 0);
    do_req(1'b1, F3_SW, 12, 64'h80000001, 0);
    do_req(1'b0, F3_LW, 12, 64'h0, 0);
    check("lw_sext", last_data, 64'hFFFFFFFF80000001);
    do_req(1'b0, F3_LWU, 12, 64'h0, 0);
    check("lwu_zext", last_data, 64'h0000000080000001);
    do_req(1'b0, F3_LD, 8, 64'h0, 5);

    for (int t = 0; t < 80; t++) begin
      f3   = 3'($urandom_range(0, 7));
      sz   = 1 << f3[1:0];
      addr = $urandom_range(0, 127);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % sz);
      do_req(1'($urandom_range(0, 1)), f3, addr, {$urandom, $urandom}, $urandom_range(0, 2));
    end

    // reset in the read phase of a read-modify-write store
    @(negedge Clock);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqFunct3 = F3_SH;
    bus.ReqAddress = 64'd0; bus.ReqWriteData = 64'hBEEF;
    @(posedge Clock);
    #1 bus.ReqValid = 1'b0;
    @(negedge Clock);
    check("abort_state", 64'(dbg_state), 64'(ST_STORE_RD));
    check("abort_mem_read_before", 64'(bus.MemRead), 64'd1);
    Reset = 1'b1;
    #1;
    check("abort_mem_read", 64'(bus.MemRead), 64'd0);
    check("abort_mem_write", 64'(bus.MemWrite), 64'd0);
    check("abort_resp_valid", 64'(bus.RespValid), 64'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("abort_req_ready", 64'(bus.ReqReady), 64'd1);
    check("abort_resp_valid_after", 64'(bus.RespValid), 64'd0);
    check("abort_dword0", mem[0], ref_dword(0));

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_dword(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
